imem_fetch_loader: RTL
======================

# imem_fetch_loader

Parametrised, byte-addressed, big-endian instruction memory with a registered fetch port, a byte-serial program loader, and hardware clear after reset. It sits between the PC/fetch stage and the program source (testbench or boot interface) and replaces the fixed 128-byte combinational instruction ROM. Fetch uses a one-cycle req/valid handshake with range and alignment error reporting. Memory contents are loaded at run time, not from a hard-coded host file path.

## Interface
- `DEPTH`, 128: memory size in bytes; must be a power of two, ≥ 8.
- `ADDR_W`, 32: fetch and load address width.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `fetch_req` input 1: fetch request; accepted only when `fetch_ready` = 1.
- `fetch_addr` input ADDR_W: byte address of the instruction's MSB byte.
- `fetch_ready` output 1: high only in IDLE.
- `fetch_valid` output 1: one-cycle pulse, the cycle after acceptance.
- `fetch_inst` output 32: `{mem[a], mem[a+1], mem[a+2], mem[a+3]}`; held until the next response.
- `fetch_err` output 1: qualifies `fetch_valid`; range or alignment fault.
- `load_start` input 1: starts a load session at `load_base`.
- `load_base` input ADDR_W: first byte address of the session.
- `load_valid` input 1: `load_byte` is written this cycle (LOAD state only).
- `load_byte` input 8: data byte.
- `load_done` input 1: ends the session.
- `load_cnt` output ADDR_W: number of bytes accepted in the current or last session.
- `load_ovf` output 1: sticky; set when any session write fell outside memory.

## Operation
- States:
  - CLEAR → IDLE after the last clear write.
  - IDLE → LOAD on `load_start`.
  - LOAD → IDLE on `load_done`.
- CLEAR: entered on reset. `clr_ptr` walks 0 to DEPTH-4 in steps of 4 and zeroes 4 bytes per cycle, so CLEAR lasts DEPTH/4 cycles. `load_*` inputs are ignored during CLEAR.
- IDLE, fetch accepted:
  - Compute `a = fetch_addr` with full ADDR_W+1-bit arithmetic; `a+3` must not wrap.
  - Range fault when `a+3 > DEPTH-1`. The response then has `fetch_inst` = 0 and `fetch_err` = 1.
  - Otherwise `fetch_inst` = the big-endian word at `a` and `fetch_err` = 0.
- IDLE, `load_start`:
  - `wptr` ← `load_base`, `load_cnt` ← 0. `load_ovf` is not cleared; only reset clears it.
  - If `fetch_req` is asserted in the same cycle, the fetch is still accepted and returns the pre-load contents.
- LOAD, per `load_valid` cycle:
  - If `wptr < DEPTH`, write `mem[wptr]` ← `load_byte` and increment `load_cnt`.
  - Otherwise drop the byte and set `load_ovf`.
  - `wptr` increments in both cases and saturates at all-ones; it never wraps.
- LOAD end: `load_done` returns the block to IDLE. If `load_valid` and `load_done` arrive together, the byte is written first. `load_start` during LOAD is ignored.
- Fetch requests outside IDLE are ignored: no response and no queueing.
- Reset asserted at any point aborts any load or fetch and re-enters CLEAR. Contents are zeroed again.

## Timing
- Reset values:
  - `fetch_ready` = 0, `fetch_valid` = 0, `fetch_inst` = 0, `fetch_err` = 0.
  - `load_cnt` = 0, `load_ovf` = 0.
  - State = CLEAR, `clr_ptr` = 0.
- `fetch_ready` first rises DEPTH/4 cycles after reset deasserts (32 cycles for the default DEPTH).
- Fetch latency: request accepted at edge N; `fetch_valid`, `fetch_inst` and `fetch_err` are registered and visible after edge N+1. Back-to-back requests give one response per cycle.
- A load write at edge N is visible to a fetch accepted at edge N+1 or later.
- `load_cnt` and `load_ovf` update on the same edge as the write.

## Configuration
- `IMEM_ALIGN_CHECK_EN`, defined:
  - `fetch_addr[1:0]` ≠ 0 is a fault: `fetch_err` = 1 and `fetch_inst` = 0.
  - Alignment is checked before range.
- `IMEM_ALIGN_CHECK_EN`, undefined:
  - Unaligned addresses are legal and return 4 consecutive bytes starting at `a`.
  - Only the range fault exists.

## Test plan
- Reset release, fetch at 0 in the first ready cycle → `fetch_ready` rises after 32 cycles (DEPTH = 128); response 0x00000000 with `fetch_err` = 0.
- Load session at base 0 with bytes 0x00,0x50,0x00,0x93 then `load_done`; fetch at 0 on the next cycle → `fetch_inst` = 0x00500093 and `load_cnt` = 4.
- Load at base 126 with 4 bytes → `load_cnt` = 2 and `load_ovf` = 1; fetch at 124 returns bytes 124..127 with `fetch_err` = 0; fetch at 125 → `fetch_err` = 1 and `fetch_inst` = 0.
- Fetch at 0x2 → with `IMEM_ALIGN_CHECK_EN`: `fetch_err` = 1 and `fetch_inst` = 0; without it: bytes 2..5 with `fetch_err` = 0.
- `fetch_req` together with `load_start` in IDLE → response carries the old word; `fetch_ready` = 0 during LOAD; a request during LOAD produces no `fetch_valid`.
- Reset asserted mid-load after 3 bytes → all outputs return to their reset values; after CLEAR, a fetch at 0 returns 0x00000000.

Source files
------------

// File: rtl/imem_fetch_loader.sv
// ============================================================================
// Module   : imem_fetch_loader
// Purpose  : Byte-addressed big-endian instruction memory with registered
//            fetch port, byte-serial loader and post-reset hardware clear.
//            Optional macro IMEM_ALIGN_CHECK_EN adds word-alignment faults.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_fetch_loader #(
    parameter int DEPTH  = 128,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_req_i,
    input  logic [ADDR_W-1:0] fetch_addr_i,
    output logic              fetch_ready_o,
    output logic              fetch_valid_o,
    output logic [31:0]       fetch_inst_o,
    output logic              fetch_err_o,
    input  logic              load_start_i,
    input  logic [ADDR_W-1:0] load_base_i,
    input  logic              load_valid_i,
    input  logic [7:0]        load_byte_i,
    input  logic              load_done_i,
    output logic [ADDR_W-1:0] load_cnt_o,
    output logic              load_ovf_o
);

    localparam int              MEM_AW    = $clog2(DEPTH);
    localparam logic [1:0]      ST_CLEAR  = 2'd0;
    localparam logic [1:0]      ST_IDLE   = 2'd1;
    localparam logic [1:0]      ST_LOAD   = 2'd2;
    localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W+1)'(DEPTH);
    localparam logic [MEM_AW-1:0] CLR_LAST = MEM_AW'(DEPTH-4);

    logic [7:0]        mem_q [DEPTH];
    logic [1:0]        state_q, state_d;
    logic [MEM_AW-1:0] clr_ptr_q, clr_ptr_d;
    logic [ADDR_W-1:0] wptr_q, wptr_d;
    logic [ADDR_W-1:0] load_cnt_q, load_cnt_d;
    logic              load_ovf_q, load_ovf_d;
    logic              fetch_valid_q, fetch_valid_d;
    logic [31:0]       fetch_inst_q, fetch_inst_d;
    logic              fetch_err_q, fetch_err_d;

    logic              fetch_acc;
    logic [ADDR_W:0]   addr_end;
    logic              range_err;
    logic              align_err;
    logic [MEM_AW-1:0] rd_base;
    logic [31:0]       rd_word;
    logic              load_in_range;
    logic              load_wr;
    logic              clr_wr;

    always_comb begin
        fetch_acc = (state_q == ST_IDLE) && fetch_req_i;
        // Extra bit keeps a+3 from wrapping near the top of the address space
        addr_end  = {1'b0, fetch_addr_i} + (ADDR_W+1)'(3);
        range_err = (addr_end >= DEPTH_EXT);
`ifdef IMEM_ALIGN_CHECK_EN
        align_err = |fetch_addr_i[1:0];
`else
        align_err = 1'b0;
`endif
        rd_base = fetch_addr_i[MEM_AW-1:0];
        rd_word = {mem_q[rd_base],
                   mem_q[rd_base + MEM_AW'(1)],
                   mem_q[rd_base + MEM_AW'(2)],
                   mem_q[rd_base + MEM_AW'(3)]};
        load_in_range = ({1'b0, wptr_q} < DEPTH_EXT);
        load_wr = (state_q == ST_LOAD) && load_valid_i && load_in_range;
        clr_wr  = (state_q == ST_CLEAR);
    end

    always_comb begin
        state_d       = state_q;
        clr_ptr_d     = clr_ptr_q;
        wptr_d        = wptr_q;
        load_cnt_d    = load_cnt_q;
        load_ovf_d    = load_ovf_q;
        fetch_valid_d = fetch_acc;
        fetch_inst_d  = fetch_inst_q;
        fetch_err_d   = fetch_err_q;

        if (fetch_acc) begin
            fetch_err_d  = align_err | range_err;
            fetch_inst_d = (align_err | range_err) ? 32'h0 : rd_word;
        end

        case (state_q)
            ST_CLEAR: begin
                clr_ptr_d = clr_ptr_q + MEM_AW'(4);
                if (clr_ptr_q == CLR_LAST) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (load_start_i) begin
                    state_d    = ST_LOAD;
                    wptr_d     = load_base_i;
                    load_cnt_d = '0;
                end
            end
            ST_LOAD: begin
                if (load_valid_i) begin
                    if (load_in_range) begin
                        load_cnt_d = load_cnt_q + ADDR_W'(1);
                    end else begin
                        load_ovf_d = 1'b1;
                    end
                    // Saturate so an overflowing session can never wrap back into memory
                    wptr_d = (&wptr_q) ? wptr_q : wptr_q + ADDR_W'(1);
                end
                if (load_done_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_CLEAR;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_CLEAR;
            clr_ptr_q     <= '0;
            wptr_q        <= '0;
            load_cnt_q    <= '0;
            load_ovf_q    <= 1'b0;
            fetch_valid_q <= 1'b0;
            fetch_inst_q  <= 32'h0;
            fetch_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            clr_ptr_q     <= clr_ptr_d;
            wptr_q        <= wptr_d;
            load_cnt_q    <= load_cnt_d;
            load_ovf_q    <= load_ovf_d;
            fetch_valid_q <= fetch_valid_d;
            fetch_inst_q  <= fetch_inst_d;
            fetch_err_q   <= fetch_err_d;
        end
    end

    // Storage has no reset; the CLEAR walk zeroes it after every reset
    always_ff @(posedge clk) begin
        if (clr_wr) begin
            for (int k = 0; k < 4; k++) begin
                mem_q[clr_ptr_q + MEM_AW'(k)] <= 8'h00;
            end
        end else if (load_wr) begin
            mem_q[wptr_q[MEM_AW-1:0]] <= load_byte_i;
        end
    end

    assign fetch_ready_o = (state_q == ST_IDLE);
    assign fetch_valid_o = fetch_valid_q;
    assign fetch_inst_o  = fetch_inst_q;
    assign fetch_err_o   = fetch_err_q;
    assign load_cnt_o    = load_cnt_q;
    assign load_ovf_o    = load_ovf_q;

endmodule

`default_nettype wire
